ctrl_m: RTL and testbench

Instruction sequencer for the 8-bit accumulator CPU. It sits directly upstream of `alu_m` and the accumulator register. It steps every instruction through a fixed 8-phase cycle and decodes the current `opcode` into the memory, IR, PC and accumulator strobes. It consumes `alu_m`'s `zero` flag for SKZ. It also owns HLT stall/resume and an optional retired-instruction counter.

---
 rtl/ctrl_m.sv | 122 ++++++++++++
 tb/tb_ctrl_m.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_m.sv
// ctrl_m: 8-phase instruction sequencer for the 8-bit accumulator CPU.
// Decodes phase and opcode into memory, IR, PC and accumulator strobes.
// It also handles the HLT stall and its resume.
// Optional feature macro: CTRL_RETIRE_CNT_EN builds the saturating
// retired-instruction counter. When the macro is undefined, retired is tied to 0.

package ex_type_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;
endpackage

module ctrl_m
  import ex_type_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  opcode_e              opcode,
  input  logic                 zero,
  input  logic                 resume,
  output logic                 mem_rd,
  output logic                 load_ir,
  output logic                 halt,
  output logic                 inc_pc,
  output logic                 load_ac,
  output logic                 load_pc,
  output logic                 mem_wr,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  phase_e phase_q;
  phase_e phase_d;
  logic   aluop;

  assign aluop = (opcode inside {ADD, AND, XOR, LDA});
  assign phase = phase_q;

  // Phase register: advances every clock except while stalled on HLT.
  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= INST_ADDR;
    else     phase_q <= phase_d;
  end

  // Next-phase and strobe decode from the current phase and opcode.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    phase_d = phase_e'(phase_q + 3'd1);
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    unique case (phase_q)
      INST_ADDR: ;
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = (opcode == HLT);
        inc_pc = (opcode != HLT) || resume;
        // Hold here until resume releases the HLT stall.
        if (opcode == HLT && !resume) phase_d = phase_q;
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        load_ac = aluop;
        mem_rd  = aluop;
        inc_pc  = (opcode == SKZ) && zero;
        load_pc = (opcode == JMP);
      end
      STORE: begin
        load_ac = aluop;
        mem_rd  = aluop;
        inc_pc  = (opcode == JMP);
        load_pc = (opcode == JMP);
        mem_wr  = (opcode == STO);
      end
      default: ;
    endcase
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] retired_q;

  // Retired counter: count on the edge leaving STORE, and saturate at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_q <= '0;
    else if (phase_q == STORE && retired_q != '1) retired_q <= retired_q + 1'b1;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_ctrl_m.sv
// tb_ctrl_m: randomized self-checking bench for ctrl_m.
// An instruction-level reference model tracks the expected phase and the retired count.
// Every cycle, the DUT outputs are compared with that model.
// A second instance with CNT_WIDTH=2 exercises counter saturation.

module tb_ctrl_m;
  import ex_type_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  opcode_e     opcode;
  logic        zero;
  logic        resume;

  logic        mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic [2:0]  phase;
  logic [15:0] retired;

  logic        s_mem_rd, s_load_ir, s_halt, s_inc_pc, s_load_ac, s_load_pc, s_mem_wr;
  logic [2:0]  s_phase;
  logic [1:0]  s_retired;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the expected phase and the total number of instructions retired.
  int m_phase = 0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  ctrl_m #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
    .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .phase(phase), .retired(retired)
  );

  ctrl_m #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
    .mem_rd(s_mem_rd), .load_ir(s_load_ir), .halt(s_halt), .inc_pc(s_inc_pc),
    .load_ac(s_load_ac), .load_pc(s_load_pc), .mem_wr(s_mem_wr),
    .phase(s_phase), .retired(s_retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected strobes {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}.
  // Each strobe is derived from the phase table.
  function automatic logic [6:0] exp_strobes(int ph, opcode_e op, logic z, logic rs);
    logic alu, rd, ir, hl, ip, ac, lp, wr;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    rd  = (ph == 1) || (ph == 2) || (ph == 3) || ((ph >= 5) && alu);
    ir  = (ph == 2) || (ph == 3);
    hl  = (ph == 4) && (op == HLT);
    ip  = ((ph == 4) && ((op != HLT) || rs)) ||
          ((ph == 6) && (op == SKZ) && z) ||
          ((ph == 7) && (op == JMP));
    ac  = (ph >= 6) && alu;
    lp  = (ph >= 6) && (op == JMP);
    wr  = (ph == 7) && (op == STO);
    return {rd, ir, hl, ip, ac, lp, wr};
  endfunction

  function automatic int exp_retired(int width);
    int lim;
    lim = (1 << width) - 1;
`ifdef CTRL_RETIRE_CNT_EN
    return (m_cnt > lim) ? lim : m_cnt;
`else
    return 0 * lim;
`endif
  endfunction

  task automatic compare_all(input logic in_reset);
    logic [6:0] e;
    e = in_reset ? 7'd0 : exp_strobes(m_phase, opcode, zero, resume);
    check($sformatf("phase op=%s", opcode.name()), {29'd0, phase}, m_phase);
    check($sformatf("strobes ph=%0d op=%s z=%b rs=%b", m_phase, opcode.name(), zero, resume),
          {25'd0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}, {25'd0, e});
    check("retired", {16'd0, retired}, exp_retired(16));
    check("retired_sat", {30'd0, s_retired}, exp_retired(2));
  endtask

  // Runs one clock: drive the inputs after the falling edge, compare, and then advance the model at the rising edge.
  task automatic cyc(input opcode_e op, input logic z, input logic rs);
    opcode = op;
    zero   = z;
    resume = rs;
    #1;
    compare_all(1'b0);
    @(posedge clk);
    if (!(m_phase == 4 && op == HLT && !rs)) begin
      if (m_phase == 7) m_cnt++;
      m_phase = (m_phase + 1) % 8;
    end
    @(negedge clk);
  endtask

  // Runs one whole instruction, starting from phase 0.
  // For HLT, resume stays low for `stalls` cycles in phase 4.
  task automatic run_instr(input opcode_e op, input logic z, input int stalls);
    int left = stalls;
    int guard = 0;
    logic rs;
    do begin
      if (m_phase == 4 && op == HLT) begin
        rs = (left == 0);
        if (left > 0) left--;
      end else begin
        rs = 1'($urandom_range(0, 1));
      end
      cyc(op, z, rs);
      guard++;
    end while (m_phase != 0 && guard < 200);
    if (guard >= 200) check("instr_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    opcode = ADD;
    zero = 1'b0;
    resume = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    compare_all(1'b1);
    rst = 1'b0;
    m_phase = 0;
    m_cnt = 0;

    // Directed scenarios from the phase table.
    run_instr(ADD, 1'b0, 0);
    run_instr(SKZ, 1'b1, 0);
    run_instr(SKZ, 1'b0, 0);
    run_instr(JMP, 1'b0, 0);
    run_instr(STO, 1'b1, 0);
    run_instr(HLT, 1'b0, 10);
    run_instr(HLT, 1'b1, 0);
    run_instr(LDA, 1'b0, 0);

    // Random instruction stream.
    for (int i = 0; i < 40; i++) begin
      opcode_e op;
      op = opcode_e'($urandom_range(0, 7));
      run_instr(op, 1'($urandom_range(0, 1)), (op == HLT) ? int'($urandom_range(0, 5)) : 0);
    end

    // Asynchronous reset in the middle of phase 6.
    while (m_phase != 6) cyc(ADD, 1'b0, 1'b0);
    opcode = ADD;
    rst = 1'b1;
    #1;
    m_phase = 0;
    m_cnt = 0;
    compare_all(1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    compare_all(1'b1);
    rst = 1'b0;

    // Reset in the middle of a HLT stall, after the counter has moved.
    run_instr(ADD, 1'b0, 0);
    for (int i = 0; i < 4; i++) cyc(HLT, 1'b0, (m_phase == 4) ? 1'b0 : 1'b1);
    for (int i = 0; i < 3; i++) cyc(HLT, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    m_phase = 0;
    m_cnt = 0;
    compare_all(1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      opcode_e op;
      op = opcode_e'($urandom_range(0, 7));
      run_instr(op, 1'($urandom_range(0, 1)), (op == HLT) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
